// File: rtl/fc_binary_layer.sv
// ============================================================================
// Module  : fc_binary_layer
// Brief   : Binary (XNOR/popcount) fully-connected layer, 10 neurons, serial input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fc_binary_layer #(
    parameter int IN_LEN = 121,
    parameter int N_OUT  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    fc_din,
    input  logic                    fc_din_valid,
    input  logic [N_OUT-1:0]        w_din,
    input  logic                    w_valid,
    output logic signed [9:0]       fc_result_0,
    output logic signed [9:0]       fc_result_1,
    output logic signed [9:0]       fc_result_2,
    output logic signed [9:0]       fc_result_3,
    output logic signed [9:0]       fc_result_4,
    output logic signed [9:0]       fc_result_5,
    output logic signed [9:0]       fc_result_6,
    output logic signed [9:0]       fc_result_7,
    output logic signed [9:0]       fc_result_8,
    output logic signed [9:0]       fc_result_9,
    output logic                    fc_result_valid,
    output logic                    busy
);

    localparam int             c_AW   = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam logic [c_AW-1:0] c_LAST = c_AW'(IN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_AW-1:0]        r_in_idx;
    logic [c_AW-1:0]        r_w_addr;
    logic signed [9:0]      r_acc [N_OUT];
    logic                   r_result_valid;
    logic [N_OUT-1:0]       r_mem [2**c_AW];

    logic [N_OUT-1:0]       w_rd;
    logic [N_OUT-1:0]       w_match;

    assign w_rd    = r_mem[r_in_idx];
    assign w_match = ~(w_rd ^ {N_OUT{fc_din}});

    // Weight memory carries no reset; it is reloaded by the host after reset.
    always_ff @(posedge clk) begin
        if (!rst && w_valid && !start && (r_state != ACCUM))
            r_mem[r_w_addr] <= w_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_in_idx       <= '0;
            r_w_addr       <= '0;
            r_result_valid <= 1'b0;
            for (int k = 0; k < N_OUT; k++) r_acc[k] <= '0;
        end else begin
            r_result_valid <= 1'b0;
            if (start) begin
                r_state  <= ACCUM;
                r_in_idx <= '0;
                r_w_addr <= '0;
                for (int k = 0; k < N_OUT; k++) r_acc[k] <= '0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (w_valid)
                            r_w_addr <= (r_w_addr == c_LAST) ? '0 : r_w_addr + 1'b1;
                    end
                    ACCUM: begin
                        if (fc_din_valid) begin
                            for (int k = 0; k < N_OUT; k++)
                                r_acc[k] <= w_match[k] ? r_acc[k] + 10'sd1 : r_acc[k] - 10'sd1;
                            if (r_in_idx == c_LAST) begin
                                r_state        <= DONE;
                                r_in_idx       <= '0;
                                r_result_valid <= 1'b1;
                            end else begin
                                r_in_idx <= r_in_idx + 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy            = (r_state == ACCUM);
    assign fc_result_valid = r_result_valid;
    assign fc_result_0     = r_acc[0];
    assign fc_result_1     = r_acc[1];
    assign fc_result_2     = r_acc[2];
    assign fc_result_3     = r_acc[3];
    assign fc_result_4     = r_acc[4];
    assign fc_result_5     = r_acc[5];
    assign fc_result_6     = r_acc[6];
    assign fc_result_7     = r_acc[7];
    assign fc_result_8     = r_acc[8];
    assign fc_result_9     = r_acc[9];

endmodule

`default_nettype wire

// File: doc/fc_binary_layer.md
FC_BINARY_LAYER -- requirements
Module: fc_binary_layer

Interface
REQ-001 SHALL have parameter IN_LEN, default 121, giving the number of input bits per inference (legal range 1..511).
REQ-002 SHALL have parameter N_OUT, default 10, giving the number of output neurons (fixed at 10; the output port list depends on it).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that clears the accumulators and begins an inference.
REQ-006 SHALL have port fc_din, input, 1, the binary activation bit (1 means +1, 0 means -1).
REQ-007 SHALL have port fc_din_valid, input, 1, qualifying fc_din.
REQ-008 SHALL have port w_din, input, 10, one weight bit per neuron for the current input index (bit k is for neuron k).
REQ-009 SHALL have port w_valid, input, 1, qualifying w_din.
REQ-010 SHALL have ports fc_result_0..fc_result_9, output, 10 each, signed, holding the neuron sums.
REQ-011 SHALL have port fc_result_valid, output, 1, a one-cycle pulse when the results are final.
REQ-012 SHALL have port busy, output, 1, high while in the ACCUM state.

Function
REQ-013 SHALL store a weight memory of IN_LEN x 10 bits, written at w_addr on each w_valid cycle while in IDLE or DONE.
REQ-014 SHALL increment w_addr after each accepted weight word, wrapping from IN_LEN-1 to 0.
REQ-015 SHALL reset w_addr to 0 on start.
REQ-016 SHALL ignore w_valid while in ACCUM: no write, and w_addr holds.
REQ-017 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-018 SHALL transition IDLE->ACCUM or DONE->ACCUM on start.
REQ-019 SHALL transition ACCUM->DONE on the edge that consumes input index IN_LEN-1.
REQ-020 SHALL restart on start in ACCUM: accumulators cleared, in_idx set to 0, stays in ACCUM.
REQ-021 SHALL, on start, clear all 10 accumulators and in_idx to 0 at that edge; fc_din_valid in the start cycle is ignored.
REQ-022 SHALL, in ACCUM with fc_din_valid=1, update every accumulator k: acc_k += 1 if fc_din XNOR weight[in_idx][k] = 1, else acc_k -= 1; then in_idx increments.
REQ-023 SHALL keep accumulators and in_idx unchanged in ACCUM when fc_din_valid=0 (gaps allowed).
REQ-024 SHALL ignore fc_din_valid in IDLE and DONE.
REQ-025 SHALL use 10-bit two's-complement accumulators; saturation is not required because |sum| <= IN_LEN <= 511.
REQ-026 SHALL drive fc_result_k directly from acc_k at all times; the value is valid and stable from fc_result_valid until the next start.
REQ-027 SHALL assert fc_result_valid for exactly one cycle, the cycle after the final input edge (first cycle in DONE).
REQ-028 SHALL give a latency of 1 cycle from the last valid input sample to the fc_result_valid high cycle.
REQ-029 SHALL give start priority over a simultaneous final input: the restart wins, and no fc_result_valid is produced.
REQ-030 SHALL drive busy = (state == ACCUM).

Reset
REQ-031 SHALL, on rst high (async), force state=IDLE, in_idx=0, w_addr=0, all acc=0, fc_result_valid=0 and busy=0.
REQ-032 SHALL leave weight memory contents unreset (don't-care); the bench must reload the weights after reset.
REQ-033 SHALL, on reset during ACCUM, abort the inference; no fc_result_valid is issued until a new start completes.
REQ-034 SHALL release from reset synchronously in effect: the first active edge after rst falls may accept start.

Verification
REQ-035 SHALL pass: weights all 1, start, 121 inputs of 1 -> all results = +121, fc_result_valid one cycle after the 121st input, busy low afterwards.
REQ-036 SHALL pass: same weights, 121 inputs of 0 -> all results = -121 (10'h387).
REQ-037 SHALL pass: neuron 3 weights all 0 and others all 1, inputs alternating 1,0 starting with 1 -> neuron 3 = -1, others = +1.
REQ-038 SHALL pass: inputs with random fc_din_valid gaps -> results identical to the gap-free run, and valid occurs one cycle after the 121st valid sample.
REQ-039 SHALL pass: start reissued after 60 inputs, then 121 inputs of 1 with weights all 1 -> results = +121, a single fc_result_valid.
REQ-040 SHALL pass: rst pulsed mid-ACCUM -> all results 0, state IDLE, no fc_result_valid; w_valid during ACCUM -> no weight change (checked by a subsequent inference).
